// File: rtl/sdram_arbiter.sv
// Two-master Avalon-MM arbiter sharing one SDRAM controller port, with a tag FIFO for pipelined reads.
// Optional build macro SDRAM_ARB_M0_PRIORITY_EN: fixed m0 priority on ties instead of round-robin.
module sdram_arbiter #(
    parameter int unsigned MAX_PENDING = 8,
    parameter int unsigned PEND_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       m0_address,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [31:0]       m0_writedata,
    input  logic [3:0]        m0_byteenable,
    output logic [31:0]       m0_readdata,
    output logic              m0_waitrequest,
    output logic              m0_readdatavalid,
    input  logic [31:0]       m1_address,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [31:0]       m1_writedata,
    input  logic [3:0]        m1_byteenable,
    output logic [31:0]       m1_readdata,
    output logic              m1_waitrequest,
    output logic              m1_readdatavalid,
    output logic [31:0]       sdram_address,
    output logic              sdram_read,
    output logic              sdram_write,
    output logic [31:0]       sdram_writedata,
    output logic [3:0]        sdram_byteenable,
    input  logic [31:0]       sdram_readdata,
    input  logic              sdram_waitrequest,
    input  logic              sdram_readdatavalid,
    output logic [PEND_W-1:0] pending,
    output logic              rdv_error
);

    localparam int unsigned PTR_W = (MAX_PENDING > 1) ? $clog2(MAX_PENDING) : 1;
    localparam logic [PEND_W-1:0] FULL_CNT = PEND_W'(MAX_PENDING);

    logic                   lock_q;
    logic                   lock_id_q;
    logic [MAX_PENDING-1:0] tag_q;
    logic [PTR_W-1:0]       head_q;
    logic [PTR_W-1:0]       tail_q;
    logic [PEND_W-1:0]      count_q;
    logic                   rdv_error_q;

    logic pop, room, elig0, elig1, tie_id;
    logic sel_valid, sel_id, sel_elig, sel_wr_req, sel_rd_req;
    logic issued, accept, push, head_id;

`ifdef SDRAM_ARB_M0_PRIORITY_EN
    assign tie_id = 1'b0;
`else
    // Preferred master for the next tie; holds the inverse of the last winner so reset favours m0.
    logic pref_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pref_q <= 1'b0;
        end else if (accept) begin
            pref_q <= ~sel_id;
        end
    end

    assign tie_id = pref_q;
`endif

    // A return in the same cycle frees a slot, so a full FIFO can still take a read.
    assign pop   = sdram_readdatavalid & (count_q != '0);
    assign room  = (count_q != FULL_CNT) | pop;
    assign elig0 = m0_write | (m0_read & room);
    assign elig1 = m1_write | (m1_read & room);

    always_comb begin
        sel_valid = 1'b0;
        sel_id    = 1'b0;
        if (lock_q) begin
            sel_valid = 1'b1;
            sel_id    = lock_id_q;
        end else if (elig0 && elig1) begin
            sel_valid = 1'b1;
            sel_id    = tie_id;
        end else if (elig0) begin
            sel_valid = 1'b1;
            sel_id    = 1'b0;
        end else if (elig1) begin
            sel_valid = 1'b1;
            sel_id    = 1'b1;
        end
    end

    assign sel_elig   = sel_id ? elig1 : elig0;
    assign sel_wr_req = sel_id ? m1_write : m0_write;
    assign sel_rd_req = sel_id ? m1_read : m0_read;

    // Write wins when a master illegally asserts both strobes.
    assign sdram_write = sel_valid & sel_elig & sel_wr_req;
    assign sdram_read  = sel_valid & sel_elig & ~sel_wr_req & sel_rd_req;

    always_comb begin
        sdram_address    = '0;
        sdram_writedata  = '0;
        sdram_byteenable = '0;
        if (sel_valid) begin
            sdram_address    = sel_id ? m1_address    : m0_address;
            sdram_writedata  = sel_id ? m1_writedata  : m0_writedata;
            sdram_byteenable = sel_id ? m1_byteenable : m0_byteenable;
        end
    end

    assign m0_waitrequest = ~(sel_valid & ~sel_id & elig0) | sdram_waitrequest;
    assign m1_waitrequest = ~(sel_valid &  sel_id & elig1) | sdram_waitrequest;

    assign issued = sdram_read | sdram_write;
    assign accept = issued & ~sdram_waitrequest;
    assign push   = sdram_read & ~sdram_waitrequest;

    assign head_id          = tag_q[head_q];
    assign m0_readdata      = sdram_readdata;
    assign m1_readdata      = sdram_readdata;
    assign m0_readdatavalid = pop & ~head_id;
    assign m1_readdatavalid = pop &  head_id;
    assign pending          = count_q;
    assign rdv_error        = rdv_error_q;

    // Grant lock: a stalled command keeps the port until the slave accepts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q    <= 1'b0;
            lock_id_q <= 1'b0;
        end else if (accept) begin
            lock_q <= 1'b0;
        end else if (issued) begin
            lock_q    <= 1'b1;
            lock_id_q <= sel_id;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tag_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                tag_q[tail_q] <= sel_id;
                tail_q        <= tail_q + PTR_W'(1);
            end
            if (pop) begin
                head_q <= head_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_q <= count_q + PEND_W'(1);
            end else if (pop && !push) begin
                count_q <= count_q - PEND_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdv_error_q <= 1'b0;
        end else if (sdram_readdatavalid && count_q == '0) begin
            rdv_error_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Self-checking bench for sdram_arbiter: directed scenarios plus a randomized run against a queue-based model.
module tb_sdram_arbiter;

    localparam int MAXP = 8;
`ifdef SDRAM_ARB_M0_PRIORITY_EN
    localparam bit PRIO = 1'b1;
`else
    localparam bit PRIO = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] m0_address, m0_writedata, m0_readdata;
    logic        m0_read, m0_write, m0_waitrequest, m0_readdatavalid;
    logic [3:0]  m0_byteenable;
    logic [31:0] m1_address, m1_writedata, m1_readdata;
    logic        m1_read, m1_write, m1_waitrequest, m1_readdatavalid;
    logic [3:0]  m1_byteenable;
    logic [31:0] sdram_address, sdram_writedata, sdram_readdata;
    logic        sdram_read, sdram_write, sdram_waitrequest, sdram_readdatavalid;
    logic [3:0]  sdram_byteenable;
    logic [3:0]  pending;
    logic        rdv_error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sdram_arbiter #(.MAX_PENDING(MAXP), .PEND_W(4)) dut (
        .clk(clk), .rst(rst),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
        .m1_readdatavalid(m1_readdatavalid),
        .sdram_address(sdram_address), .sdram_read(sdram_read), .sdram_write(sdram_write),
        .sdram_writedata(sdram_writedata), .sdram_byteenable(sdram_byteenable),
        .sdram_readdata(sdram_readdata), .sdram_waitrequest(sdram_waitrequest),
        .sdram_readdatavalid(sdram_readdatavalid),
        .pending(pending), .rdv_error(rdv_error)
    );

    task automatic clear_inputs();
        m0_address = '0; m0_read = 0; m0_write = 0; m0_writedata = '0; m0_byteenable = '0;
        m1_address = '0; m1_read = 0; m1_write = 0; m1_writedata = '0; m1_byteenable = '0;
        sdram_readdata = '0; sdram_waitrequest = 0; sdram_readdatavalid = 0;
    endtask

    // Leaves the bench at a falling edge with reset released and all inputs idle.
    task automatic apply_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic int grant_of(input int k);
        return PRIO ? 0 : (k % 2);
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        m0_read = 1'b1;
        sdram_readdatavalid = 1'b1;
        @(negedge clk); #1;
        checks++; if (pending !== 4'd0) begin errors++; $display("FAIL reset_pending got %0d want 0", pending); end
        checks++; if (rdv_error !== 1'b0) begin errors++; $display("FAIL reset_rdv_error got %b want 0", rdv_error); end
        checks++; if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0) begin
            errors++; $display("FAIL reset_rdv got %b%b want 00", m0_readdatavalid, m1_readdatavalid);
        end
    endtask

    task automatic test_single_write();
        apply_reset();
        m0_write = 1'b1; m0_address = 32'h100; m0_writedata = 32'hDEADBEEF; m0_byteenable = 4'hF;
        m1_address = 32'h5555;
        #1;
        checks++; if (sdram_write !== 1'b1 || sdram_read !== 1'b0) begin
            errors++; $display("FAIL wr_strobe got w%b r%b want w1 r0", sdram_write, sdram_read);
        end
        checks++; if (sdram_address !== 32'h100) begin errors++; $display("FAIL wr_addr got %h want 100", sdram_address); end
        checks++; if (sdram_writedata !== 32'hDEADBEEF || sdram_byteenable !== 4'hF) begin
            errors++; $display("FAIL wr_data got %h/%h want deadbeef/f", sdram_writedata, sdram_byteenable);
        end
        checks++; if (m0_waitrequest !== 1'b0 || m1_waitrequest !== 1'b1) begin
            errors++; $display("FAIL wr_wait got m0=%b m1=%b want m0=0 m1=1", m0_waitrequest, m1_waitrequest);
        end
        @(negedge clk);
        m0_write = 1'b0;
        #1;
        checks++; if (pending !== 4'd0) begin errors++; $display("FAIL wr_pending got %0d want 0", pending); end
        checks++; if (sdram_write !== 1'b0 || sdram_address !== 32'h0) begin
            errors++; $display("FAIL idle_bus got w%b a%h want w0 a0", sdram_write, sdram_address);
        end
    endtask

    task automatic test_alternate_reads();
        apply_reset();
        m0_read = 1'b1; m0_address = 32'h1000;
        m1_read = 1'b1; m1_address = 32'h2000;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (sdram_read !== 1'b1 || sdram_address !== (grant_of(k) == 1 ? 32'h2000 : 32'h1000)) begin
                errors++; $display("FAIL alt_grant%0d got r%b a%h want winner m%0d", k, sdram_read, sdram_address, grant_of(k));
            end
            @(negedge clk);
        end
        m0_read = 1'b0; m1_read = 1'b0;
        #1;
        checks++; if (pending !== 4'd4) begin errors++; $display("FAIL alt_pending got %0d want 4", pending); end
        for (int k = 0; k < 4; k++) begin
            sdram_readdatavalid = 1'b1;
            sdram_readdata = 32'(k + 1);
            #1;
            checks++; if (m0_readdatavalid !== (grant_of(k) == 0) || m1_readdatavalid !== (grant_of(k) == 1)) begin
                errors++; $display("FAIL alt_route%0d got %b%b want m%0d", k, m0_readdatavalid, m1_readdatavalid, grant_of(k));
            end
            checks++; if ((grant_of(k) == 0 ? m0_readdata : m1_readdata) !== 32'(k + 1)) begin
                errors++; $display("FAIL alt_data%0d got %h/%h want %0d", k, m0_readdata, m1_readdata, k + 1);
            end
            @(negedge clk);
        end
        sdram_readdatavalid = 1'b0;
        #1;
        checks++; if (pending !== 4'd0) begin errors++; $display("FAIL alt_drain got %0d want 0", pending); end
    endtask

    task automatic test_stall_lock();
        apply_reset();
        m1_read = 1'b1; m1_address = 32'h3000;
        sdram_waitrequest = 1'b1;
        for (int c = 0; c < 3; c++) begin
            if (c > 0) begin m0_read = 1'b1; m0_address = 32'h4000; end
            #1;
            checks++; if (sdram_address !== 32'h3000 || sdram_read !== 1'b1) begin
                errors++; $display("FAIL lock_addr%0d got %h r%b want 3000 r1", c, sdram_address, sdram_read);
            end
            checks++; if (m0_waitrequest !== 1'b1 || m1_waitrequest !== 1'b1) begin
                errors++; $display("FAIL lock_wait%0d got m0=%b m1=%b want 11", c, m0_waitrequest, m1_waitrequest);
            end
            @(negedge clk);
        end
        sdram_waitrequest = 1'b0;
        #1;
        checks++; if (sdram_address !== 32'h3000 || m1_waitrequest !== 1'b0 || m0_waitrequest !== 1'b1) begin
            errors++; $display("FAIL lock_accept got a%h m0=%b m1=%b want 3000 1 0", sdram_address, m0_waitrequest, m1_waitrequest);
        end
        @(negedge clk);
        #1;
        checks++; if (sdram_address !== 32'h4000 || m0_waitrequest !== 1'b0) begin
            errors++; $display("FAIL lock_next got a%h m0=%b want 4000 0", sdram_address, m0_waitrequest);
        end
    endtask

    task automatic test_full();
        apply_reset();
        m0_read = 1'b1;
        for (int i = 0; i < MAXP; i++) begin
            m0_address = 32'(i * 4);
            #1;
            checks++; if (sdram_read !== 1'b1 || m0_waitrequest !== 1'b0) begin
                errors++; $display("FAIL full_fill%0d got r%b w%b want r1 w0", i, sdram_read, m0_waitrequest);
            end
            @(negedge clk);
        end
        m0_address = 32'h20;
        #1;
        checks++; if (m0_waitrequest !== 1'b1 || sdram_read !== 1'b0 || pending !== 4'd8) begin
            errors++; $display("FAIL full_block got w%b r%b p%0d want w1 r0 p8", m0_waitrequest, sdram_read, pending);
        end
        @(negedge clk);
        sdram_readdatavalid = 1'b1;
        #1;
        checks++; if (m0_waitrequest !== 1'b0 || sdram_read !== 1'b1 || m0_readdatavalid !== 1'b1) begin
            errors++; $display("FAIL full_swap got w%b r%b v%b want w0 r1 v1", m0_waitrequest, sdram_read, m0_readdatavalid);
        end
        @(negedge clk);
        sdram_readdatavalid = 1'b0; m0_read = 1'b0;
        #1;
        checks++; if (pending !== 4'd8) begin errors++; $display("FAIL full_count got %0d want 8", pending); end
    endtask

    task automatic test_rdv_error();
        apply_reset();
        sdram_readdatavalid = 1'b1;
        #1;
        checks++; if (m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0 || rdv_error !== 1'b0) begin
            errors++; $display("FAIL err_pulse got %b%b e%b want 00 e0", m0_readdatavalid, m1_readdatavalid, rdv_error);
        end
        @(negedge clk);
        sdram_readdatavalid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            checks++; if (rdv_error !== 1'b1) begin errors++; $display("FAIL err_sticky%0d got %b want 1", c, rdv_error); end
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        checks++; if (rdv_error !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", rdv_error); end
    endtask

    task automatic test_reset_pending();
        apply_reset();
        m1_read = 1'b1;
        repeat (3) @(negedge clk);
        m1_read = 1'b0;
        #1;
        checks++; if (pending !== 4'd3) begin errors++; $display("FAIL rstp_before got %0d want 3", pending); end
        rst = 1'b1;
        sdram_readdatavalid = 1'b1;
        #1;
        checks++; if (pending !== 4'd0 || m0_readdatavalid !== 1'b0 || m1_readdatavalid !== 1'b0 || rdv_error !== 1'b0) begin
            errors++; $display("FAIL rstp_during got p%0d v%b%b e%b want p0 v00 e0", pending, m0_readdatavalid, m1_readdatavalid, rdv_error);
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if (m1_readdatavalid !== 1'b0) begin errors++; $display("FAIL rstp_late got %b want 0", m1_readdatavalid); end
        @(negedge clk);
        sdram_readdatavalid = 1'b0;
        #1;
        checks++; if (rdv_error !== 1'b1) begin errors++; $display("FAIL rstp_err got %b want 1", rdv_error); end
    endtask

    task automatic test_random();
        int q[$];
        int last_win, held, sel, cmd[2];
        bit err, stalled[2], elig[2], ewait[2], pop, can_read, erd, ewr, swr, rdv;
        logic [31:0] addr[2], wd[2], eaddr, ewd, rdata;
        logic [3:0] be[2];
        apply_reset();
        last_win = 1; held = -1; err = 0;
        stalled[0] = 0; stalled[1] = 0;
        for (int n = 0; n < 2000; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (!stalled[i]) begin
                    cmd[i] = int'($urandom_range(0, 2));
                    addr[i] = $urandom; wd[i] = $urandom; be[i] = 4'($urandom);
                end
            end
            swr = ($urandom_range(0, 3) == 0);
            rdv = (q.size() > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 49) == 0);
            rdata = $urandom;
            m0_read = (cmd[0] == 1); m0_write = (cmd[0] == 2);
            m0_address = addr[0]; m0_writedata = wd[0]; m0_byteenable = be[0];
            m1_read = (cmd[1] == 1); m1_write = (cmd[1] == 2);
            m1_address = addr[1]; m1_writedata = wd[1]; m1_byteenable = be[1];
            sdram_waitrequest = swr; sdram_readdatavalid = rdv; sdram_readdata = rdata;
            #1;
            pop = rdv && q.size() > 0;
            can_read = q.size() < MAXP || pop;
            for (int i = 0; i < 2; i++) elig[i] = (cmd[i] == 2) || (cmd[i] == 1 && can_read);
            if (held >= 0) sel = held;
            else if (elig[0] && elig[1]) sel = PRIO ? 0 : 1 - last_win;
            else if (elig[0]) sel = 0;
            else if (elig[1]) sel = 1;
            else sel = -1;
            ewr = sel >= 0 && elig[sel] && cmd[sel] == 2;
            erd = sel >= 0 && elig[sel] && cmd[sel] == 1;
            eaddr = (sel >= 0) ? addr[sel] : 32'h0;
            ewd = (sel >= 0) ? wd[sel] : 32'h0;
            for (int i = 0; i < 2; i++) ewait[i] = !(sel == i && elig[i]) || swr;
            checks++; if (sdram_read !== erd || sdram_write !== ewr) begin
                errors++; $display("FAIL rnd_cmd@%0d got r%b w%b want r%b w%b", n, sdram_read, sdram_write, erd, ewr);
            end
            checks++; if (sdram_address !== eaddr || sdram_writedata !== ewd) begin
                errors++; $display("FAIL rnd_bus@%0d got %h/%h want %h/%h", n, sdram_address, sdram_writedata, eaddr, ewd);
            end
            checks++; if (m0_waitrequest !== ewait[0] || m1_waitrequest !== ewait[1]) begin
                errors++; $display("FAIL rnd_wait@%0d got %b%b want %b%b", n, m0_waitrequest, m1_waitrequest, ewait[0], ewait[1]);
            end
            checks++; if (m0_readdatavalid !== (pop && q[0] == 0) || m1_readdatavalid !== (pop && q[0] == 1)) begin
                errors++; $display("FAIL rnd_rdv@%0d got %b%b want pop=%b", n, m0_readdatavalid, m1_readdatavalid, pop);
            end
            checks++; if (m0_readdata !== rdata || m1_readdata !== rdata) begin
                errors++; $display("FAIL rnd_rdata@%0d got %h/%h want %h", n, m0_readdata, m1_readdata, rdata);
            end
            checks++; if (pending !== 4'(q.size()) || rdv_error !== err) begin
                errors++; $display("FAIL rnd_state@%0d got p%0d e%b want p%0d e%b", n, pending, rdv_error, q.size(), err);
            end
            if (rdv && q.size() == 0) err = 1;
            if (pop) void'(q.pop_front());
            if ((erd || ewr) && !swr) begin
                last_win = sel; held = -1;
                if (erd) q.push_back(sel);
            end else if (erd || ewr) begin
                held = sel;
            end
            for (int i = 0; i < 2; i++) stalled[i] = (cmd[i] != 0) && ewait[i];
            @(negedge clk);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_write();
        test_alternate_reads();
        test_stall_lock();
        test_full();
        test_rdv_error();
        test_reset_pending();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
